// File: rtl/xgriscv_dmem_wait.sv
// rtl/xgriscv_dmem_wait.sv - data memory with req/ready/done handshake, fixed access latency and byte-enabled stores
//
// Parameters:
//   DEPTH_LOG2  log2 of memory depth in 32-bit words
//   LATENCY     wait cycles per access (0..15)
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req, we     access request (sampled while ready=1), 1=store 0=load
//   addr        byte address, word index addr[DEPTH_LOG2+1:2]
//   wdata, be   store data and byte enables
//   ready       request can be accepted this cycle
//   done        one-cycle completion pulse (loads and stores)
//   rdata       load data, updated only on load completion
//   err         out-of-range flag with done
// Optional feature: define XGRISCV_DMEM_RANGE_CHECK_EN to flag and suppress
// out-of-range accesses; otherwise upper address bits wrap and err is 0.
module xgriscv_dmem_wait #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        acc;

    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;

    logic        acc_we;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_be;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic        acc_in_range;

    logic [31:0] mem [DEPTH];

    assign ready   = (state == S_IDLE);
    assign acc_idx = acc_addr[DEPTH_LOG2+1:2];

    // Request capture; after acceptance the inputs are don't-care.
    always_ff @(posedge clk) begin
        if (req && state == S_IDLE) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= be;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc       = 1'b0;
        // With zero latency the access uses the live inputs on the accept edge.
        if (LATENCY == 0) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
        end else begin
            acc_we    = r_we;
            acc_addr  = r_addr;
            acc_wdata = r_wdata;
            acc_be    = r_be;
        end
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        acc = 1'b1;
                    end else begin
                        state_nxt = S_BUSY;
                        cnt_nxt   = LAT;
                    end
                end
            end
            S_BUSY: begin
                if (cnt == 4'd1) begin
                    acc       = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

`ifdef XGRISCV_DMEM_RANGE_CHECK_EN
    assign acc_in_range = ~|acc_addr[31:DEPTH_LOG2+2];
    logic unused_addr_bits;
    assign unused_addr_bits = ^acc_addr[1:0];
`else
    assign acc_in_range = 1'b1;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[31:DEPTH_LOG2+2]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            done  <= 1'b0;
            rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= acc;
            if (acc && !acc_we) begin
                rdata <= acc_in_range ? mem[acc_idx] : 32'd0;
            end
        end
    end

`ifdef XGRISCV_DMEM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= acc && !acc_in_range;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Storage is never cleared; reset only blocks the commit of a pending store.
    always_ff @(posedge clk) begin
        if (!reset && acc && acc_we && acc_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_xgriscv_dmem_wait.sv
// tb/tb_xgriscv_dmem_wait.sv - directed self-checking bench for xgriscv_dmem_wait
module tb_xgriscv_dmem_wait;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

`ifdef XGRISCV_DMEM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_req, a_we, a_ready, a_done, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        b_req, b_we, b_ready, b_done, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;
    logic        c_req, c_we, c_ready, c_done, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_be;

    xgriscv_dmem_wait #(.DEPTH_LOG2(10), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
        .be(a_be), .ready(a_ready), .done(a_done), .rdata(a_rdata), .err(a_err));
    xgriscv_dmem_wait #(.DEPTH_LOG2(10), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
        .be(b_be), .ready(b_ready), .done(b_done), .rdata(b_rdata), .err(b_err));
    xgriscv_dmem_wait #(.DEPTH_LOG2(10), .LATENCY(3)) dut_c (
        .clk(clk), .reset(reset), .req(c_req), .we(c_we), .addr(c_addr), .wdata(c_wdata),
        .be(c_be), .ready(c_ready), .done(c_done), .rdata(c_rdata), .err(c_err));

    // Drivers only: issue one access and return the number of edges from accept to done.
    task automatic a_xfer(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [3:0] b, output int n);
        int g = 0;
        while (!a_ready && g < 20) begin @(posedge clk); #1; g++; end
        a_req = 1'b1; a_we = w; a_addr = ad; a_wdata = wd; a_be = b;
        @(posedge clk); #1;
        a_req = 1'b0;
        n = 0;
        while (!a_done && n < 20) begin @(posedge clk); #1; n++; end
    endtask

    task automatic c_xfer(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [3:0] b, output int n);
        int g = 0;
        while (!c_ready && g < 20) begin @(posedge clk); #1; g++; end
        c_req = 1'b1; c_we = w; c_addr = ad; c_wdata = wd; c_be = b;
        @(posedge clk); #1;
        c_req = 1'b0;
        n = 0;
        while (!c_done && n < 20) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a: got %b expected 1", a_ready); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done_a: got %b expected 0", a_done); end
        n_checks++; if (a_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata_a: got %h expected 0", a_rdata); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err_a: got %b expected 0", a_err); end
        n_checks++; if (b_ready !== 1'b1 || b_done !== 1'b0 || b_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_b: got ready=%b done=%b rdata=%h expected 1 0 0", b_ready, b_done, b_rdata); end
        n_checks++; if (c_ready !== 1'b1 || c_done !== 1'b0 || c_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_c: got ready=%b done=%b rdata=%h expected 1 0 0", c_ready, c_done, c_rdata); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency2;
        int n;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF; a_be = 4'hF;
        @(posedge clk); #1;
        a_req = 1'b0;
        n_checks++; if (a_ready !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL l2_busy1: got ready=%b done=%b expected 0 0", a_ready, a_done); end
        @(posedge clk); #1;
        n_checks++; if (a_ready !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL l2_busy2: got ready=%b done=%b expected 0 0", a_ready, a_done); end
        @(posedge clk); #1;
        n_checks++; if (a_done !== 1'b1 || a_ready !== 1'b1) begin n_fail++; $display("FAIL l2_store_done: got done=%b ready=%b expected 1 1", a_done, a_ready); end
        a_xfer(1'b0, 32'h10, 32'h0, 4'h0, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL l2_load_latency: got %0d expected 2", n); end
        n_checks++; if (a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL l2_load_rdata: got %h expected deadbeef", a_rdata); end
        @(posedge clk); #1;
        n_checks++; if (a_done !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL l2_done_pulse: got done=%b rdata=%h expected 0 deadbeef", a_done, a_rdata); end
    endtask

    task automatic test_byte_enables;
        int n;
        a_xfer(1'b1, 32'h20, 32'h11223344, 4'hF, n);
        n_checks++; if (a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL be_rdata_hold: got %h expected deadbeef", a_rdata); end
        a_xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, n);
        a_xfer(1'b0, 32'h20, 32'h0, 4'h0, n);
        n_checks++; if (a_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_merge: got %h expected 11bb33dd", a_rdata); end
        a_xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL be_zero_done: got %0d edges expected 2", n); end
        a_xfer(1'b0, 32'h22, 32'h0, 4'h0, n);
        n_checks++; if (a_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_zero_nowrite: got %h expected 11bb33dd", a_rdata); end
    endtask

    task automatic test_latency0;
        b_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_we = 1'b1; b_addr = 32'(4 * i); b_wdata = 32'hC0DE0000 | 32'(i); b_be = 4'hF;
            @(posedge clk); #1;
            n_checks++; if (b_done !== 1'b1 || b_ready !== 1'b1) begin n_fail++; $display("FAIL l0_store%0d: got done=%b ready=%b expected 1 1", i, b_done, b_ready); end
        end
        n_checks++; if (b_rdata !== 32'd0) begin n_fail++; $display("FAIL l0_rdata_hold: got %h expected 0", b_rdata); end
        for (int i = 0; i < 4; i++) begin
            b_we = 1'b0; b_addr = 32'(4 * i);
            @(posedge clk); #1;
            n_checks++; if (b_done !== 1'b1 || b_ready !== 1'b1) begin n_fail++; $display("FAIL l0_load%0d_hs: got done=%b ready=%b expected 1 1", i, b_done, b_ready); end
            n_checks++; if (b_rdata !== (32'hC0DE0000 | 32'(i))) begin n_fail++; $display("FAIL l0_load%0d_rdata: got %h expected %h", i, b_rdata, 32'hC0DE0000 | 32'(i)); end
        end
        b_req = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (b_done !== 1'b0 || b_rdata !== 32'hC0DE0003) begin n_fail++; $display("FAIL l0_idle: got done=%b rdata=%h expected 0 c0de0003", b_done, b_rdata); end
    endtask

    task automatic test_reset_mid;
        int n;
        int seen;
        c_xfer(1'b1, 32'h40, 32'h0, 4'hF, n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL rm_l3_latency: got %0d expected 3", n); end
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'h12345678; c_be = 4'hF;
        @(posedge clk); #1;
        c_req = 1'b0;
        n_checks++; if (c_ready !== 1'b0) begin n_fail++; $display("FAIL rm_accepted: got ready=%b expected 0", c_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (c_ready !== 1'b1 || c_done !== 1'b0) begin n_fail++; $display("FAIL rm_after_reset: got ready=%b done=%b expected 1 0", c_ready, c_done); end
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (c_done) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_no_done: got %0d done pulses expected 0", seen); end
        c_req = 1'b1; c_we = 1'b1; c_wdata = 32'h87654321;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; c_req = 1'b0;
        n_checks++; if (c_ready !== 1'b1) begin n_fail++; $display("FAIL rm_req_dropped: got ready=%b expected 1", c_ready); end
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (c_done) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_dropped_no_done: got %0d done pulses expected 0", seen); end
        c_xfer(1'b0, 32'h40, 32'h0, 4'h0, n);
        n_checks++; if (c_rdata !== 32'h0 || n !== 3) begin n_fail++; $display("FAIL rm_load: got rdata=%h edges=%0d expected 0 3", c_rdata, n); end
    endtask

    task automatic test_range;
        int n;
        a_xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, n);
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rng_inrange_err: got %b expected 0", a_err); end
        a_xfer(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, n);
        n_checks++; if (a_err !== RC || n !== 2) begin n_fail++; $display("FAIL rng_store: got err=%b edges=%0d expected %b 2", a_err, n, RC); end
        @(posedge clk); #1;
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rng_err_pulse: got %b expected 0", a_err); end
        a_xfer(1'b0, 32'h0, 32'h0, 4'h0, n);
        n_checks++; if (a_rdata !== (RC ? 32'hCAFEF00D : 32'hFFFFFFFF) || a_err !== 1'b0) begin n_fail++; $display("FAIL rng_load0: got rdata=%h err=%b expected %h 0", a_rdata, a_err, RC ? 32'hCAFEF00D : 32'hFFFFFFFF); end
        a_xfer(1'b0, 32'h1000, 32'h0, 4'h0, n);
        n_checks++; if (a_rdata !== (RC ? 32'h0 : 32'hFFFFFFFF) || a_err !== RC) begin n_fail++; $display("FAIL rng_load_oor: got rdata=%h err=%b expected %h %b", a_rdata, a_err, RC ? 32'h0 : 32'hFFFFFFFF, RC); end
    endtask

    task automatic test_hold;
        int n;
        a_xfer(1'b1, 32'h34, 32'h01020304, 4'hF, n);
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'h55AA55AA; a_be = 4'hF;
        @(posedge clk); #1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 32'h34; a_wdata = 32'h0BADBAD0; a_be = 4'h3;
        @(posedge clk); #1;
        a_we = 1'b1; a_addr = 32'h38;
        @(posedge clk); #1;
        n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b expected 1", a_done); end
        a_xfer(1'b0, 32'h30, 32'h0, 4'h0, n);
        n_checks++; if (a_rdata !== 32'h55AA55AA) begin n_fail++; $display("FAIL hold_orig: got %h expected 55aa55aa", a_rdata); end
        a_xfer(1'b0, 32'h34, 32'h0, 4'h0, n);
        n_checks++; if (a_rdata !== 32'h01020304) begin n_fail++; $display("FAIL hold_other: got %h expected 01020304", a_rdata); end
    endtask

    initial begin
        test_reset;
        test_latency2;
        test_byte_enables;
        test_latency0;
        test_reset_mid;
        test_range;
        test_hold;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
